// File: rtl/um_fetch_dispatch_pkg.sv
// Shared bus types, opcode and dispatch-state enums for the fetch/dispatch stage
// and the per-instruction execution FSMs it controls.
package um_fetch_dispatch_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] offset;
        logic [1:0]  mode;
    } mem_in_bus_t;

    typedef struct packed {
        logic [2:0]  sel;
        logic        mode;
        logic [31:0] data;
    } reg_in_bus_t;

    typedef enum logic [3:0] {
        CMOV     = 4'd0,
        AINDEX   = 4'd1,
        AAMEND   = 4'd2,
        ADD      = 4'd3,
        MUL      = 4'd4,
        DIV      = 4'd5,
        NAND     = 4'd6,
        HALT     = 4'd7,
        ALLOC    = 4'd8,
        ABANDON  = 4'd9,
        OUTPUT   = 4'd10,
        INPUT    = 4'd11,
        LOADPROG = 4'd12,
        LOADIMM  = 4'd13
    } um_opcode_t;

    typedef enum logic [2:0] {
        StFetchReq,
        StFetchWait,
        StDecode,
        StExec,
        StLoadImm,
        StPcUpdate,
        StHalt,
        StFault
    } dispatch_state_t;

    localparam logic [3:0] OP_HALT     = 4'd7;
    localparam logic [3:0] OP_LOADPROG = 4'd12;
    localparam logic [3:0] OP_LOADIMM  = 4'd13;

    localparam logic [1:0] MEM_MODE_READ = 2'b00;

endpackage

// File: rtl/um_fetch_dispatch_decode.sv
// Combinational instruction-word decoder, shared with the trace monitor.
module um_instr_decode
    import um_fetch_dispatch_pkg::*;
(
    input  logic [31:0] ir_i,
    output um_opcode_t  opcode_o,
    output logic [2:0]  a_o,
    output logic [2:0]  b_o,
    output logic [2:0]  c_o,
    output logic [2:0]  imm_sel_o,
    output logic [31:0] imm_val_o,
    output logic        valid_o,
    output logic        is_halt_o,
    output logic        is_loadimm_o
);

    logic [3:0] op_raw;

    always_comb begin
        op_raw       = ir_i[31:28];
        opcode_o     = um_opcode_t'(op_raw);
        a_o          = ir_i[8:6];
        b_o          = ir_i[5:3];
        c_o          = ir_i[2:0];
        imm_sel_o    = ir_i[27:25];
        imm_val_o    = {7'b0, ir_i[24:0]};
        // Opcodes 14 and 15 have no execution unit.
        valid_o      = (op_raw <= OP_LOADIMM);
        is_halt_o    = (op_raw == OP_HALT);
        is_loadimm_o = (op_raw == OP_LOADIMM);
    end

endmodule

// File: rtl/um_fetch_dispatch.sv
// Fetches instruction words from the code array, decodes them and releases one
// execution FSM at a time; halt and load-immediate are handled locally.
module um_fetch_dispatch
    import um_fetch_dispatch_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned NUM_OPS     = 14,
    parameter logic [31:0] CODE_ARRAY  = 32'h0
) (
    input  logic               clk,
    input  logic               r,
    input  logic [31:0]        mem_data_out_bus,
    input  logic [NUM_OPS-1:0] op_finished,
    input  logic [31:0]        load_pc,
    output mem_in_bus_t        mem_in,
    output reg_in_bus_t        reg_in,
    output logic               own_bus,
    output logic [NUM_OPS-1:0] op_hold,
    output logic [31:0]        pc,
    output logic [31:0]        retired,
    output logic               halted,
    output logic               fault
);

    dispatch_state_t state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     retired_q, retired_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            exec_active;

    um_opcode_t      dec_opcode;
    logic [3:0]      op_idx;
    logic [2:0]      dec_a, dec_b, dec_c;
    logic [2:0]      dec_imm_sel;
    logic [31:0]     dec_imm_val;
    logic            dec_valid, dec_is_halt, dec_is_loadimm;

    um_instr_decode u_decode (
        .ir_i        (ir_q),
        .opcode_o    (dec_opcode),
        .a_o         (dec_a),
        .b_o         (dec_b),
        .c_o         (dec_c),
        .imm_sel_o   (dec_imm_sel),
        .imm_val_o   (dec_imm_val),
        .valid_o     (dec_valid),
        .is_halt_o   (dec_is_halt),
        .is_loadimm_o(dec_is_loadimm)
    );

    assign op_idx = dec_opcode;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        cnt_d       = cnt_q;
        exec_active = 1'b0;
        own_bus     = 1'b1;
        mem_in      = '{address: CODE_ARRAY, offset: pc_q, mode: MEM_MODE_READ};
        reg_in      = '{sel: 3'd0, mode: 1'b0, data: 32'd0};

        unique case (state_q)
            StFetchReq: begin
                cnt_d   = 2'd0;
                state_d = StFetchWait;
            end
            StFetchWait: begin
                if (cnt_q == 2'(MEM_LATENCY - 1)) begin
                    ir_d    = mem_data_out_bus;
                    state_d = StDecode;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDecode: begin
                if (!dec_valid) begin
                    state_d = StFault;
                end else if (dec_is_halt) begin
                    state_d = StHalt;
                end else if (dec_is_loadimm) begin
                    state_d = StLoadImm;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                exec_active = 1'b1;
                own_bus     = 1'b0;
                // Finished bits of FSMs still held in reset are never consulted.
                if (op_finished[op_idx]) begin
                    state_d = StPcUpdate;
                end
            end
            StLoadImm: begin
                reg_in  = '{sel: dec_imm_sel, mode: 1'b1, data: dec_imm_val};
                state_d = StPcUpdate;
            end
            StPcUpdate: begin
                retired_d = retired_q + 32'd1;
                pc_d      = (op_idx == OP_LOADPROG) ? load_pc : pc_q + 32'd1;
                state_d   = StFetchReq;
            end
            StHalt:  state_d = StHalt;
            StFault: state_d = StFault;
            default: state_d = StFetchReq;
        endcase
    end

    always_comb begin
        op_hold = '1;
        for (int i = 0; i < int'(NUM_OPS); i++) begin
            if (exec_active && (op_idx == 4'(i))) begin
                op_hold[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!r) begin
            state_q   <= StFetchReq;
            pc_q      <= 32'd0;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;
    assign halted  = (state_q == StHalt);
    assign fault   = (state_q == StFault);

endmodule

// File: tb/tb_um_fetch_dispatch.sv
// Directed bench for um_fetch_dispatch: small code memory with one-cycle read
// latency, hand-sequenced execution-FSM finished pulses.
module tb_um_fetch_dispatch;
    import um_fetch_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        r   = 1'b0;
    logic [31:0] mem_data_out_bus = 32'd0;
    logic [13:0] op_finished = 14'd0;
    logic [31:0] load_pc = 32'd0;
    mem_in_bus_t mem_in;
    reg_in_bus_t reg_in;
    logic        own_bus;
    logic [13:0] op_hold;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:31];
    int checks = 0;
    int errors = 0;

    um_fetch_dispatch #(
        .MEM_LATENCY(1),
        .NUM_OPS    (14),
        .CODE_ARRAY (32'h0)
    ) dut (
        .clk             (clk),
        .r               (r),
        .mem_data_out_bus(mem_data_out_bus),
        .op_finished     (op_finished),
        .load_pc         (load_pc),
        .mem_in          (mem_in),
        .reg_in          (reg_in),
        .own_bus         (own_bus),
        .op_hold         (op_hold),
        .pc              (pc),
        .retired         (retired),
        .halted          (halted),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    // One-cycle read latency memory indexed by the low offset bits.
    always @(posedge clk) mem_data_out_bus <= mem[mem_in.offset[4:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = 32'hD2000041;  // loadimm reg1 = 0x41
        mem[1]  = 32'h30000053;  // add A=1 B=2 C=3
        mem[2]  = 32'hC0000000;  // load program
        mem[16] = 32'h70000000;  // halt

        // Reset
        r = 1'b0;
        step(2);
        check("rst_pc", pc, 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_op_hold", 32'(op_hold), 32'h3FFF);
        check("rst_own_bus", 32'(own_bus), 32'h1);
        check("rst_reg_mode", 32'(reg_in.mode), 32'h0);
        check("rst_mem_mode", 32'(mem_in.mode), 32'h0);
        r = 1'b1;

        // Load-immediate at pc 0: FETCH_WAIT, DECODE, LOADIMM
        step(3);
        check("li_reg_mode", 32'(reg_in.mode), 32'h1);
        check("li_reg_sel", 32'(reg_in.sel), 32'h1);
        check("li_reg_data", reg_in.data, 32'h41);
        check("li_op_hold", 32'(op_hold), 32'h3FFF);
        step(1);
        check("li_pcupd_reg_mode", 32'(reg_in.mode), 32'h0);
        step(1);
        check("li_pc", pc, 32'h1);
        check("li_retired", retired, 32'h1);
        check("li_fetch_offset", mem_in.offset, 32'h1);

        // Add at pc 1: EXEC with finished arriving on the second EXEC cycle
        step(3);
        check("add_op_hold", 32'(op_hold), 32'h3FF7);
        check("add_own_bus", 32'(own_bus), 32'h0);
        op_finished = 14'h0020;  // unrelated FSM's flag must be ignored
        step(1);
        check("add_still_exec", 32'(own_bus), 32'h0);
        op_finished = 14'h0008;
        step(1);
        op_finished = 14'h0000;
        check("add_pcupd_op_hold", 32'(op_hold), 32'h3FFF);
        check("add_pcupd_own_bus", 32'(own_bus), 32'h1);
        step(1);
        check("add_pc", pc, 32'h2);
        check("add_retired", retired, 32'h2);

        // Load program at pc 2: finished already high on first EXEC cycle
        step(3);
        check("lp_op_hold", 32'(op_hold), 32'h2FFF);
        load_pc     = 32'h00000010;
        op_finished = 14'h1000;
        step(1);
        op_finished = 14'h0000;
        step(1);
        check("lp_pc", pc, 32'h10);
        check("lp_fetch_offset", mem_in.offset, 32'h10);
        check("lp_retired", retired, 32'h3);

        // Halt at pc 0x10
        step(3);
        check("halt_flag", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("halt_mem_mode", 32'(mem_in.mode), 32'h0);
        end
        check("halt_pc_frozen", pc, 32'h10);
        check("halt_retired_frozen", retired, 32'h3);
        check("halt_still", 32'(halted), 32'h1);

        // Invalid opcode
        mem[0] = 32'hE0000000;
        r = 1'b0;
        step(1);
        check("rst2_halted", 32'(halted), 32'h0);
        check("rst2_pc", pc, 32'h0);
        r = 1'b1;
        step(3);
        check("fault_flag", 32'(fault), 32'h1);
        check("fault_op_hold", 32'(op_hold), 32'h3FFF);
        step(4);
        check("fault_sticky", 32'(fault), 32'h1);
        check("fault_pc", pc, 32'h0);
        check("fault_retired", retired, 32'h0);
        r = 1'b0;
        step(1);
        check("fault_clear", 32'(fault), 32'h0);
        check("fault_clear_pc", pc, 32'h0);

        // Reset during EXEC of opcode 1
        mem[0] = 32'h10000000;
        r = 1'b1;
        step(3);
        check("aidx_op_hold", 32'(op_hold), 32'h3FFD);
        r = 1'b0;
        step(1);
        check("midrst_op_hold", 32'(op_hold), 32'h3FFF);
        check("midrst_own_bus", 32'(own_bus), 32'h1);
        check("midrst_offset", mem_in.offset, 32'h0);

        // PC wrap: jump to 0xFFFFFFFF, then retire a load-immediate there
        mem[0]  = 32'hC0000000;
        mem[31] = 32'hD2000041;
        r = 1'b1;
        step(3);
        load_pc     = 32'hFFFFFFFF;
        op_finished = 14'h1000;
        step(1);
        op_finished = 14'h0000;
        step(1);
        check("wrap_pc_max", pc, 32'hFFFFFFFF);
        step(3);
        check("wrap_li_data", reg_in.data, 32'h41);
        step(2);
        check("wrap_pc_zero", pc, 32'h0);
        check("wrap_retired", retired, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
